// File: rtl/execute_stage_pkg.sv
// Shared constants and types for the execute stage: opcodes, function fields,
// FSM state encoding and the multiply/divide operation selector.
package execute_stage_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL  = 3'b000;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic {ST_IDLE, ST_BUSY} exe_state_e;

  typedef enum logic [1:0] {MD_MUL, MD_DIVU, MD_REMU} md_op_e;

endpackage

// File: rtl/execute_stage_if.sv
// Decode-to-execute and execute-to-memory/fetch signal bundle.
// The master side is decode (drives operands), the slave side is the execute stage.
interface execute_stage_if
  import execute_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  logic            EXE_V;
  logic [31:0]     EXE_IR;
  logic [XLEN-1:0] ALU1;
  logic [XLEN-1:0] ALU2;
  logic [XLEN-1:0] TARGET_ADDRESS;
  logic [XLEN-1:0] MEM_ADDRESS;

  logic [4:0]      EXE_RD;
  logic            EXE_BUSY;
  logic            MEM_V;
  logic [31:0]     MEM_IR;
  logic [XLEN-1:0] MEM_RESULT;
  logic [XLEN-1:0] MEM_ADDR;
  logic [XLEN-1:0] MEM_STORE_DATA;
  logic            BR_TAKEN;
  logic [XLEN-1:0] BR_TARGET;

  modport master (
    output EXE_V, EXE_IR, ALU1, ALU2, TARGET_ADDRESS, MEM_ADDRESS,
    input  EXE_RD, EXE_BUSY, MEM_V, MEM_IR, MEM_RESULT, MEM_ADDR,
           MEM_STORE_DATA, BR_TAKEN, BR_TARGET
  );

  modport slave (
    input  EXE_V, EXE_IR, ALU1, ALU2, TARGET_ADDRESS, MEM_ADDRESS,
    output EXE_RD, EXE_BUSY, MEM_V, MEM_IR, MEM_RESULT, MEM_ADDR,
           MEM_STORE_DATA, BR_TAKEN, BR_TARGET
  );

endinterface

// File: rtl/execute_stage_muldiv_unit.sv
// Iterative shift-add multiplier and restoring unsigned divider, one bit per cycle.
// done/result are presented combinationally during the final iteration so the caller can register them.
module muldiv_unit
  import execute_stage_pkg::*;
#(
  parameter int XLEN          = XLEN_DEFAULT,
  parameter int MULDIV_CYCLES = 64
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  md_op_e          op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(MULDIV_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(MULDIV_CYCLES - 1);

  // MUL: acc = product, x = shifting multiplicand, y = shifting multiplier.
  // DIVU/REMU: acc = partial remainder, x = divisor, y = dividend shifting into quotient.
  md_op_e          op_q;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] acc, x, y;
  logic [XLEN-1:0] acc_n, x_n, y_n;
  logic [XLEN:0]   shifted, diff;

  always_comb begin
    acc_n   = acc;
    x_n     = x;
    y_n     = y;
    shifted = {acc, y[XLEN-1]};
    diff    = shifted - {1'b0, x};
    if (op_q == MD_MUL) begin
      if (y[0]) acc_n = acc + x;
      x_n = x << 1;
      y_n = y >> 1;
    end else if (!diff[XLEN]) begin
      acc_n = diff[XLEN-1:0];
      y_n   = {y[XLEN-2:0], 1'b1};
    end else begin
      acc_n = shifted[XLEN-1:0];
      y_n   = {y[XLEN-2:0], 1'b0};
    end
  end

  assign done   = busy && (count == LAST);
  assign result = (op_q == MD_DIVU) ? y_n : acc_n;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      busy  <= 1'b0;
      count <= '0;
      op_q  <= MD_MUL;
      acc   <= '0;
      x     <= '0;
      y     <= '0;
    end else if (start && !busy) begin
      busy  <= 1'b1;
      count <= '0;
      op_q  <= op;
      acc   <= '0;
      x     <= (op == MD_MUL) ? op_a : op_b;
      y     <= (op == MD_MUL) ? op_b : op_a;
    end else if (busy) begin
      acc   <= acc_n;
      x     <= x_n;
      y     <= y_n;
      busy  <= !done;
      count <= done ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU/branch/memory-address ops plus an iterative
// MUL/DIVU/REMU path that stalls decode while the muldiv_unit runs.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int XLEN          = XLEN_DEFAULT,
  parameter int MULDIV_CYCLES = 64
) (
  input  logic           CLK,
  input  logic           RESET,
  execute_stage_if.slave bus
);

  localparam int SHW = $clog2(XLEN);

  exe_state_e state_q, state_d;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rd_out;
  logic [SHW-1:0]  shamt;
  logic            dec_known, dec_writes, dec_md, dec_taken;
  md_op_e          dec_md_op;
  logic [XLEN-1:0] dec_result, dec_addr, dec_store, dec_target;
  logic            accept, md_start, md_busy, md_done;
  logic [XLEN-1:0] md_result;
  logic [31:0]     md_ir_q;

  assign opcode = bus.EXE_IR[6:0];
  assign rd     = bus.EXE_IR[11:7];
  assign funct3 = bus.EXE_IR[14:12];
  assign funct7 = bus.EXE_IR[31:25];
  assign shamt  = bus.ALU2[SHW-1:0];

  always_comb begin
    dec_known  = 1'b0;
    dec_writes = 1'b0;
    dec_md     = 1'b0;
    dec_md_op  = MD_MUL;
    dec_taken  = 1'b0;
    dec_result = '0;
    dec_addr   = '0;
    dec_store  = '0;
    dec_target = '0;
    case (opcode)
      OP_RTYPE: begin
        if (funct7 == F7_BASE) begin
          dec_known  = 1'b1;
          dec_writes = 1'b1;
          case (funct3)
            F3_ADD_SUB: dec_result = bus.ALU1 + bus.ALU2;
            F3_SLL:     dec_result = bus.ALU1 << shamt;
            F3_SLT:     dec_result = {{(XLEN-1){1'b0}}, $signed(bus.ALU1) < $signed(bus.ALU2)};
            F3_SLTU:    dec_result = {{(XLEN-1){1'b0}}, bus.ALU1 < bus.ALU2};
            F3_XOR:     dec_result = bus.ALU1 ^ bus.ALU2;
            F3_SRL_SRA: dec_result = bus.ALU1 >> shamt;
            F3_OR:      dec_result = bus.ALU1 | bus.ALU2;
            F3_AND:     dec_result = bus.ALU1 & bus.ALU2;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          dec_known  = 1'b1;
          dec_writes = 1'b1;
          dec_result = bus.ALU1 - bus.ALU2;
        end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
          dec_known  = 1'b1;
          dec_writes = 1'b1;
          dec_result = $signed(bus.ALU1) >>> shamt;
        end else if (funct7 == F7_MULDIV &&
                     (funct3 == F3_MUL || funct3 == F3_DIVU || funct3 == F3_REMU)) begin
          dec_md     = 1'b1;
          dec_writes = 1'b1;
          dec_md_op  = (funct3 == F3_MUL) ? MD_MUL : (funct3 == F3_DIVU) ? MD_DIVU : MD_REMU;
        end
      end
      OP_LOAD: begin
        dec_known  = (funct3 != 3'b111);
        dec_writes = dec_known;
        dec_addr   = bus.MEM_ADDRESS;
      end
      OP_STORE: begin
        dec_known = !funct3[2];
        dec_addr  = bus.MEM_ADDRESS;
        dec_store = bus.ALU2;
      end
      OP_BRANCH: begin
        dec_known  = 1'b1;
        dec_target = bus.TARGET_ADDRESS;
        case (funct3)
          F3_BEQ:  dec_taken = (bus.ALU1 == bus.ALU2);
          F3_BNE:  dec_taken = (bus.ALU1 != bus.ALU2);
          F3_BLT:  dec_taken = ($signed(bus.ALU1) < $signed(bus.ALU2));
          F3_BGE:  dec_taken = ($signed(bus.ALU1) >= $signed(bus.ALU2));
          F3_BLTU: dec_taken = (bus.ALU1 < bus.ALU2);
          F3_BGEU: dec_taken = (bus.ALU1 >= bus.ALU2);
          default: dec_known = 1'b0;
        endcase
      end
      OP_JAL: begin
        dec_known  = 1'b1;
        dec_writes = 1'b1;
        dec_taken  = 1'b1;
        dec_target = bus.TARGET_ADDRESS;
        dec_result = bus.ALU1;
      end
      OP_LUI, OP_AUIPC: begin
        dec_known  = 1'b1;
        dec_writes = 1'b1;
        dec_result = bus.ALU1;
      end
      default: ;
    endcase
  end

  assign accept   = bus.EXE_V && (state_q == ST_IDLE);
  assign md_start = accept && dec_md;
  assign rd_out   = (dec_writes && rd != 5'd0) ? rd : 5'd0;

  muldiv_unit #(
    .XLEN          (XLEN),
    .MULDIV_CYCLES (MULDIV_CYCLES)
  ) u_muldiv (
    .CLK    (CLK),
    .RESET  (RESET),
    .start  (md_start),
    .op     (dec_md_op),
    .op_a   (bus.ALU1),
    .op_b   (bus.ALU2),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (md_start) state_d = ST_BUSY;
      ST_BUSY: if (md_done || !md_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.EXE_BUSY = (state_q == ST_BUSY);

  // EXE_RD is captured at acceptance and held through BUSY and the MEM_V cycle.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      bus.MEM_V          <= 1'b0;
      bus.MEM_IR         <= '0;
      bus.MEM_RESULT     <= '0;
      bus.MEM_ADDR       <= '0;
      bus.MEM_STORE_DATA <= '0;
      bus.BR_TAKEN       <= 1'b0;
      bus.BR_TARGET      <= '0;
      bus.EXE_RD         <= '0;
      md_ir_q            <= '0;
    end else if (state_q == ST_IDLE) begin
      bus.MEM_V          <= accept && dec_known;
      bus.MEM_IR         <= (accept && dec_known) ? bus.EXE_IR : 32'd0;
      bus.MEM_RESULT     <= (accept && dec_known) ? dec_result : '0;
      bus.MEM_ADDR       <= (accept && dec_known) ? dec_addr : '0;
      bus.MEM_STORE_DATA <= (accept && dec_known) ? dec_store : '0;
      bus.BR_TAKEN       <= accept && dec_known && dec_taken;
      bus.BR_TARGET      <= (accept && dec_known) ? dec_target : '0;
      bus.EXE_RD         <= (accept && (dec_known || dec_md)) ? rd_out : 5'd0;
      if (md_start) md_ir_q <= bus.EXE_IR;
    end else if (md_done) begin
      bus.MEM_V      <= 1'b1;
      bus.MEM_IR     <= md_ir_q;
      bus.MEM_RESULT <= md_result;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage: ALU, branch, memory, muldiv and reset cases
// with hand-computed expectations.
module tb_execute_stage;

  localparam int XLEN = 64;
  localparam int MDC  = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_ADD0  = 32'h00208033;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_SRA   = 32'h4020D1B3;
  localparam logic [31:0] I_SRL   = 32'h0020D1B3;
  localparam logic [31:0] I_SLT   = 32'h0020A1B3;
  localparam logic [31:0] I_SLTU  = 32'h0020B1B3;
  localparam logic [31:0] I_BEQ   = 32'h00208063;
  localparam logic [31:0] I_BLT   = 32'h0020C063;
  localparam logic [31:0] I_BLTU  = 32'h0020E063;
  localparam logic [31:0] I_JAL   = 32'h000000EF;
  localparam logic [31:0] I_LD    = 32'h0000B283;
  localparam logic [31:0] I_SD    = 32'h0020B023;
  localparam logic [31:0] I_LUI   = 32'h000003B7;
  localparam logic [31:0] I_BAD   = 32'h0000007F;
  localparam logic [31:0] I_DIV   = 32'h0220C233;
  localparam logic [31:0] I_MUL   = 32'h02208233;
  localparam logic [31:0] I_DIVU  = 32'h0220D233;
  localparam logic [31:0] I_REMU  = 32'h0220F233;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  int compared   = 0;
  int mismatched = 0;

  execute_stage_if #(.XLEN(XLEN)) bus ();

  execute_stage #(
    .XLEN          (XLEN),
    .MULDIV_CYCLES (MDC)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  // Present one instruction for exactly one rising edge, then drop EXE_V; returns at a falling edge.
  task automatic applyStimulus(input logic v, input logic [31:0] ir, input logic [63:0] a1,
                               input logic [63:0] a2, input logic [63:0] tgt, input logic [63:0] maddr);
    bus.EXE_V          = v;
    bus.EXE_IR         = ir;
    bus.ALU1           = a1;
    bus.ALU2           = a2;
    bus.TARGET_ADDRESS = tgt;
    bus.MEM_ADDRESS    = maddr;
    @(negedge CLK);
    bus.EXE_V = 1'b0;
  endtask

  task automatic checkSingle(input string tag, input logic v, input logic [31:0] ir,
                             input logic [63:0] res, input logic [4:0] rd, input logic taken);
    checkOutput({tag, ".mem_v"},  {63'd0, bus.MEM_V}, {63'd0, v});
    checkOutput({tag, ".mem_ir"}, {32'd0, bus.MEM_IR}, {32'd0, ir});
    checkOutput({tag, ".result"}, bus.MEM_RESULT, res);
    checkOutput({tag, ".rd"},     {59'd0, bus.EXE_RD}, {59'd0, rd});
    checkOutput({tag, ".taken"},  {63'd0, bus.BR_TAKEN}, {63'd0, taken});
  endtask

  task automatic runMulDiv(input string tag, input logic [31:0] ir, input logic [63:0] a1,
                           input logic [63:0] a2, input logic [63:0] expected);
    int cycles;
    logic sawMemV;
    applyStimulus(1'b1, ir, a1, a2, 64'd0, 64'd0);
    checkOutput({tag, ".busy_start"}, {63'd0, bus.EXE_BUSY}, 64'd1);
    checkOutput({tag, ".rd_busy"}, {59'd0, bus.EXE_RD}, 64'd4);
    cycles  = 0;
    sawMemV = 1'b0;
    while (bus.EXE_BUSY === 1'b1 && cycles < 200) begin
      cycles++;
      if (bus.MEM_V !== 1'b0) sawMemV = 1'b1;
      if (cycles == 5) begin
        bus.EXE_V  = 1'b1;
        bus.EXE_IR = I_ADD;
        bus.ALU1   = 64'h1234;
        bus.ALU2   = 64'h5678;
      end
      if (cycles == 10) bus.EXE_V = 1'b0;
      @(negedge CLK);
    end
    checkOutput({tag, ".busy_cycles"}, 64'(cycles), 64'(MDC));
    checkOutput({tag, ".memv_during_busy"}, {63'd0, sawMemV}, 64'd0);
    checkSingle(tag, 1'b1, ir, expected, 5'd4, 1'b0);
  endtask

  initial begin
    int cycles;
    logic sawMemV;
    bus.EXE_V = 1'b0; bus.EXE_IR = '0; bus.ALU1 = '0; bus.ALU2 = '0;
    bus.TARGET_ADDRESS = '0; bus.MEM_ADDRESS = '0;
    RESET = 1'b0;
    @(negedge CLK);

    $display("[TB] reset with EXE_V asserted");
    applyStimulus(1'b1, I_ADD, 64'd5, 64'd7, 64'd0, 64'd0);
    applyStimulus(1'b1, I_ADD, 64'd5, 64'd7, 64'd0, 64'd0);
    checkSingle("reset", 1'b0, 32'd0, 64'd0, 5'd0, 1'b0);
    checkOutput("reset.busy", {63'd0, bus.EXE_BUSY}, 64'd0);
    checkOutput("reset.br_target", bus.BR_TARGET, 64'd0);

    RESET = 1'b1;
    applyStimulus(1'b1, I_ADD, 64'd5, 64'd7, 64'd0, 64'd0);
    checkSingle("add", 1'b1, I_ADD, 64'd12, 5'd3, 1'b0);
    applyStimulus(1'b0, I_ADD, 64'd5, 64'd7, 64'd0, 64'd0);
    checkSingle("idle", 1'b0, 32'd0, 64'd0, 5'd0, 1'b0);

    applyStimulus(1'b1, I_SUB, 64'd0, 64'd1, 64'd0, 64'd0);
    checkSingle("sub", 1'b1, I_SUB, ONES, 5'd3, 1'b0);
    applyStimulus(1'b1, I_SRA, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 64'd0);
    checkSingle("sra", 1'b1, I_SRA, ONES, 5'd3, 1'b0);
    applyStimulus(1'b1, I_SRL, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 64'd0);
    checkSingle("srl", 1'b1, I_SRL, 64'd1, 5'd3, 1'b0);
    applyStimulus(1'b1, I_SLT, ONES, 64'd1, 64'd0, 64'd0);
    checkSingle("slt", 1'b1, I_SLT, 64'd1, 5'd3, 1'b0);
    applyStimulus(1'b1, I_SLTU, ONES, 64'd1, 64'd0, 64'd0);
    checkSingle("sltu", 1'b1, I_SLTU, 64'd0, 5'd3, 1'b0);
    applyStimulus(1'b1, I_ADD0, 64'd2, 64'd3, 64'd0, 64'd0);
    checkSingle("add_x0", 1'b1, I_ADD0, 64'd5, 5'd0, 1'b0);

    applyStimulus(1'b1, I_BLT, ONES, 64'd1, 64'h1000, 64'd0);
    checkSingle("blt", 1'b1, I_BLT, 64'd0, 5'd0, 1'b1);
    checkOutput("blt.target", bus.BR_TARGET, 64'h1000);
    applyStimulus(1'b1, I_BLTU, ONES, 64'd1, 64'h1000, 64'd0);
    checkSingle("bltu", 1'b1, I_BLTU, 64'd0, 5'd0, 1'b0);
    applyStimulus(1'b1, I_BEQ, 64'd7, 64'd7, 64'h2000, 64'd0);
    checkSingle("beq", 1'b1, I_BEQ, 64'd0, 5'd0, 1'b1);
    applyStimulus(1'b0, I_BEQ, 64'd7, 64'd7, 64'h2000, 64'd0);
    checkOutput("after_branch.taken", {63'd0, bus.BR_TAKEN}, 64'd0);

    applyStimulus(1'b1, I_JAL, 64'h2004, 64'd0, 64'h3000, 64'd0);
    checkSingle("jal", 1'b1, I_JAL, 64'h2004, 5'd1, 1'b1);
    checkOutput("jal.target", bus.BR_TARGET, 64'h3000);

    applyStimulus(1'b1, I_LD, 64'd0, 64'd0, 64'd0, 64'h4008);
    checkSingle("ld", 1'b1, I_LD, 64'd0, 5'd5, 1'b0);
    checkOutput("ld.addr", bus.MEM_ADDR, 64'h4008);
    applyStimulus(1'b1, I_SD, 64'd0, 64'hDEAD, 64'd0, 64'h5010);
    checkSingle("sd", 1'b1, I_SD, 64'd0, 5'd0, 1'b0);
    checkOutput("sd.addr", bus.MEM_ADDR, 64'h5010);
    checkOutput("sd.data", bus.MEM_STORE_DATA, 64'hDEAD);

    applyStimulus(1'b1, I_LUI, 64'h1234_5000, 64'd0, 64'd0, 64'd0);
    checkSingle("lui", 1'b1, I_LUI, 64'h1234_5000, 5'd7, 1'b0);
    applyStimulus(1'b1, I_BAD, 64'd1, 64'd2, 64'h10, 64'h20);
    checkSingle("bad_opcode", 1'b0, 32'd0, 64'd0, 5'd0, 1'b0);
    applyStimulus(1'b1, I_DIV, 64'd100, 64'd7, 64'd0, 64'd0);
    checkSingle("signed_div", 1'b0, 32'd0, 64'd0, 5'd0, 1'b0);
    checkOutput("signed_div.busy", {63'd0, bus.EXE_BUSY}, 64'd0);

    $display("[TB] multiply / divide");
    runMulDiv("mul", I_MUL, 64'h1_0000_0000, 64'h1_0000_0003, 64'h3_0000_0000);
    runMulDiv("divu_0", I_DIVU, 64'd100, 64'd0, ONES);
    runMulDiv("remu_0", I_REMU, 64'd100, 64'd0, 64'd100);
    runMulDiv("divu_7", I_DIVU, 64'd100, 64'd7, 64'd14);
    runMulDiv("remu_7", I_REMU, 64'd100, 64'd7, 64'd2);

    $display("[TB] reset during divide");
    applyStimulus(1'b1, I_DIVU, 64'd100, 64'd7, 64'd0, 64'd0);
    repeat (29) @(negedge CLK);
    checkOutput("abort.busy_before", {63'd0, bus.EXE_BUSY}, 64'd1);
    RESET = 1'b0;
    @(negedge CLK);
    checkSingle("abort", 1'b0, 32'd0, 64'd0, 5'd0, 1'b0);
    checkOutput("abort.busy", {63'd0, bus.EXE_BUSY}, 64'd0);
    RESET = 1'b1;
    cycles  = 0;
    sawMemV = 1'b0;
    while (cycles < 80) begin
      cycles++;
      if (bus.MEM_V !== 1'b0 || bus.EXE_BUSY !== 1'b0) sawMemV = 1'b1;
      @(negedge CLK);
    end
    checkOutput("abort.no_late_result", {63'd0, sawMemV}, 64'd0);
    applyStimulus(1'b1, I_ADD, 64'd10, 64'd20, 64'd0, 64'd0);
    checkSingle("add_after_abort", 1'b1, I_ADD, 64'd30, 5'd3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
